// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding-select and load-use hazard unit for the mips789 pipeline.
//   Each source operand is compared against NSTAGES downstream write ports
//   (stage 1 = nearest producer). The ID-stage selects feed the branch
//   comparator and are purely combinational. The EX-stage selects come from
//   source numbers registered out of ID. A load-use stall is raised when the
//   nearest producer of a used source has no result yet. On a stall, flush
//   or empty ID slot a bubble is inserted into EX. A saturating counter
//   tracks the number of stall cycles.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   id_rn        : ID source register numbers, source i at [i*REG_AW +: REG_AW]
//   id_use       : source i is read by the ID instruction
//   id_valid     : ID holds a real instruction
//   flush        : kill the ID instruction
//   st_we        : write enable of each forwardable stage (bit k-1 = stage k)
//   st_rn        : destination register of each stage
//   st_rdy       : result of each stage is available this cycle
//   id_fw_sel    : ID compare forward select per source (0 = register file)
//   ex_fw_sel    : EX operand forward select per source (0 = register file)
//   stall        : hold PC and IF/ID this cycle
//   ex_valid     : EX holds a real instruction
//   stall_cnt    : saturating stall-cycle count
module fwd_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int NSTAGES   = 2,
    parameter int SELW      = 2,
    parameter int ZERO_HARD = 1,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rn,
    input  logic [NUM_SRC-1:0]          id_use,
    input  logic                        id_valid,
    input  logic                        flush,
    input  logic [NSTAGES-1:0]          st_we,
    input  logic [NSTAGES*REG_AW-1:0]   st_rn,
    input  logic [NSTAGES-1:0]          st_rdy,
    output logic [NUM_SRC*SELW-1:0]     id_fw_sel,
    output logic [NUM_SRC*SELW-1:0]     ex_fw_sel,
    output logic                        stall,
    output logic                        ex_valid,
    output logic [CNT_W-1:0]            stall_cnt
);

    // Nearest matching producer for a register number; 0 when none.
    // Scanning from the far stage down lets the nearest match overwrite.
    function automatic logic [SELW-1:0] nearest(input logic [REG_AW-1:0] rn);
        logic [SELW-1:0] sel;
        sel = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (st_we[k] && st_rn[k*REG_AW +: REG_AW] == rn &&
                !(ZERO_HARD != 0 && rn == '0))
                sel = SELW'(k + 1);
        end
        return sel;
    endfunction

    // True when the selected source (0 = register file) has data now.
    function automatic logic sel_ready(input logic [SELW-1:0] sel);
        logic rdy;
        rdy = 1'b1;
        for (int k = 0; k < NSTAGES; k++) begin
            if (sel == SELW'(k + 1))
                rdy = st_rdy[k];
        end
        return rdy;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == '1)
            return c;
        return c + 1'b1;
    endfunction

    logic [NUM_SRC*REG_AW-1:0] ex_rn_p1;
    logic [NUM_SRC-1:0]        ex_use_p1;
    logic                      vld_p1;
    logic                      hazard;

    // ---- stage p0: ID compare selects and load-use detection ----
    always_comb begin
        id_fw_sel = '0;
        hazard    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid && id_use[i]) begin
                id_fw_sel[i*SELW +: SELW] = nearest(id_rn[i*REG_AW +: REG_AW]);
                if (!sel_ready(nearest(id_rn[i*REG_AW +: REG_AW])))
                    hazard = 1'b1;
            end
        end
    end

    // Flush wins over stall: a killed instruction never waits on a load.
    assign stall = id_valid && !flush && hazard;

    // ---- stage p1: EX source registers and bubble insertion ----
    always_ff @(posedge clk) begin
        if (rst || flush || stall || !id_valid) begin
            ex_rn_p1  <= '0;
            ex_use_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            ex_rn_p1  <= id_rn;
            ex_use_p1 <= id_use;
            vld_p1    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign ex_valid = vld_p1;

    always_comb begin
        ex_fw_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vld_p1 && ex_use_p1[i])
                ex_fw_sel[i*SELW +: SELW] = nearest(ex_rn_p1[i*REG_AW +: REG_AW]);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed bench for fwd_hazard_unit (CNT_W=4, other parameters default).
//   The driver applies one input vector per cycle and queues the outputs
//   expected for that cycle; the monitor pops and compares on the falling
//   edge. Selects are packed {rt, rs}; st_rn is packed {stage2, stage1}.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rn;
    logic [1:0]  id_use;
    logic        id_valid;
    logic        flush;
    logic [1:0]  st_we;
    logic [9:0]  st_rn;
    logic [1:0]  st_rdy;
    logic [3:0]  id_fw_sel;
    logic [3:0]  ex_fw_sel;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  stall_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_use(id_use),
        .id_valid(id_valid), .flush(flush), .st_we(st_we), .st_rn(st_rn),
        .st_rdy(st_rdy), .id_fw_sel(id_fw_sel), .ex_fw_sel(ex_fw_sel),
        .stall(stall), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
    );

    typedef struct {
        string      nm;
        logic [3:0] id;
        logic [3:0] ex;
        logic       st;
        logic       exv;
        logic [3:0] cnt;
        logic [4:0] mask;   // {cnt, exv, stall, ex, id}
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [3:0] act, input logic [3:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[0]) chk(e.nm, "id_fw_sel", id_fw_sel, e.id);
                if (e.mask[1]) chk(e.nm, "ex_fw_sel", ex_fw_sel, e.ex);
                if (e.mask[2]) chk(e.nm, "stall", {3'b0, stall}, {3'b0, e.st});
                if (e.mask[3]) chk(e.nm, "ex_valid", {3'b0, ex_valid}, {3'b0, e.exv});
                if (e.mask[4]) chk(e.nm, "stall_cnt", stall_cnt, e.cnt);
                // An EX select may only name a stage whose result is ready.
                if (e.mask[1]) begin
                    for (int i = 0; i < 2; i++) begin
                        logic [1:0] s;
                        s = ex_fw_sel[i*2 +: 2];
                        compared++;
                        if (s > 2'd2 || (s != 2'd0 && !st_rdy[s - 2'd1])) begin
                            mismatched++;
                            $display("FAIL %s.ex_sel_ready[%0d]: sel %0d st_rdy %b",
                                     e.nm, i, s, st_rdy);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic r,
                       input logic [9:0] rn, input logic [1:0] us,
                       input logic v, input logic fl,
                       input logic [1:0] we, input logic [9:0] srn,
                       input logic [1:0] rdy,
                       input logic [3:0] e_id, input logic [3:0] e_ex,
                       input logic e_st, input logic e_exv,
                       input logic [3:0] e_cnt, input logic [4:0] mask);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rn = rn; id_use = us; id_valid = v; flush = fl;
        st_we = we; st_rn = srn; st_rdy = rdy;
        e.nm = nm; e.id = e_id; e.ex = e_ex; e.st = e_st;
        e.exv = e_exv; e.cnt = e_cnt; e.mask = mask;
        q.push_back(e);
    endtask

    localparam logic [9:0] RS5_RT7 = {5'd7, 5'd5};
    localparam logic [9:0] RS4_RT7 = {5'd7, 5'd4};
    localparam logic [9:0] ST0_4   = {5'd0, 5'd4};

    initial begin
        int waited;
        rst = 1'b1; id_rn = '0; id_use = '0; id_valid = 1'b0; flush = 1'b0;
        st_we = '0; st_rn = '0; st_rdy = '0;

        //   name        rst rn       use   v     fl    we     srn               rdy    id     ex     st    exv   cnt   mask
        cyc("rst0",      1,  '0,      2'b00, 1'b0, 1'b0, 2'b00, '0,              2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0, 5'b00101);
        cyc("rst1",      1,  '0,      2'b00, 1'b0, 1'b0, 2'b00, '0,              2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0, 5'b11111);
        cyc("alu_fwd",   0,  RS5_RT7, 2'b11, 1'b1, 1'b0, 2'b01, {5'd0, 5'd5},    2'b11, 4'h1, 4'h0, 1'b0, 1'b0, 4'd0, 5'b11111);
        cyc("ex_fwd",    0,  '0,      2'b00, 1'b0, 1'b0, 2'b11, {5'd7, 5'd5},    2'b11, 4'h0, 4'h9, 1'b0, 1'b1, 4'd0, 5'b11111);
        cyc("prio",      0,  {5'd9, 5'd9}, 2'b11, 1'b1, 1'b0, 2'b11, {5'd9, 5'd9}, 2'b11, 4'h5, 4'h0, 1'b0, 1'b0, 4'd0, 5'b11111);
        cyc("zero_reg",  0,  '0,      2'b11, 1'b1, 1'b0, 2'b11, '0,              2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 4'd0, 5'b11111);
        cyc("load_use",  0,  RS4_RT7, 2'b11, 1'b1, 1'b0, 2'b01, ST0_4,           2'b00, 4'h1, 4'h0, 1'b1, 1'b1, 4'd0, 5'b11111);
        cyc("load_done", 0,  RS4_RT7, 2'b11, 1'b1, 1'b0, 2'b01, ST0_4,           2'b01, 4'h1, 4'h0, 1'b0, 1'b0, 4'd1, 5'b11111);
        cyc("after_ld",  0,  '0,      2'b00, 1'b0, 1'b0, 2'b01, ST0_4,           2'b01, 4'h0, 4'h1, 1'b0, 1'b1, 4'd1, 5'b11111);
        cyc("unused",    0,  RS4_RT7, 2'b10, 1'b1, 1'b0, 2'b01, ST0_4,           2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1, 5'b11111);
        cyc("flush",     0,  RS4_RT7, 2'b11, 1'b1, 1'b1, 2'b01, ST0_4,           2'b00, 4'h1, 4'h0, 1'b0, 1'b1, 4'd1, 5'b11111);
        cyc("post_fl",   0,  '0,      2'b00, 1'b0, 1'b0, 2'b00, '0,              2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1, 5'b11111);
        cyc("rst_sat",   1,  '0,      2'b00, 1'b0, 1'b0, 2'b00, '0,              2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1, 5'b11111);
        for (int j = 0; j < 20; j++)
            cyc("sat_hold", 0, RS4_RT7, 2'b01, 1'b1, 1'b0, 2'b01, ST0_4, 2'b00,
                4'h1, 4'h0, 1'b1, 1'b0, (j > 15) ? 4'd15 : 4'(j), 5'b11111);
        cyc("rst_mid",   1,  RS4_RT7, 2'b01, 1'b1, 1'b0, 2'b01, ST0_4,           2'b00, 4'h1, 4'h0, 1'b1, 1'b0, 4'd15, 5'b11111);
        cyc("post_rst",  0,  '0,      2'b00, 1'b0, 1'b0, 2'b00, '0,              2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0, 5'b11111);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the mips789 pipeline.
- Per-source mux selects for the ID-stage branch-compare operands (combinational) and the EX-stage ALU operands (source numbers registered from ID).
- Compares sources against NSTAGES downstream write ports (stage 1 = nearest, e.g. ALU; stage 2 = MEM; ...).
- Generates a load-use stall, inserts EX bubbles, and keeps a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register-number width.
- NUM_SRC, 2, source operands per instruction (rs, rt, ...).
- NSTAGES, 2, number of forwardable write stages.
- SELW, 2, forward-select width; must satisfy 2^SELW > NSTAGES.
- ZERO_HARD, 1, when 1, register 0 never forwards and never stalls.
- CNT_W, 16, stall-counter width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- id_rn, in, NUM_SRC*REG_AW, ID source register numbers; source i is at [i*REG_AW +: REG_AW].
- id_use, in, NUM_SRC, source i is actually read by the ID instruction.
- id_valid, in, 1, ID holds a real instruction.
- flush, in, 1, kill the ID instruction (taken branch or exception).
- st_we, in, NSTAGES, stage k-1 writes a register.
- st_rn, in, NSTAGES*REG_AW, destination register of each stage.
- st_rdy, in, NSTAGES, stage result is available this cycle; 0 for a load still in flight.
- id_fw_sel, out, NUM_SRC*SELW, ID compare forward select per source.
- ex_fw_sel, out, NUM_SRC*SELW, EX ALU/dmem forward select per source.
- stall, out, 1, hold PC and the IF/ID registers this cycle.
- ex_valid, out, 1, EX holds a real instruction.
- stall_cnt, out, CNT_W, saturating count of stall cycles.

Behaviour:
- Select encoding:
  - 0 = no forward (register-file value).
  - k = stage k (1..NSTAGES).
  - Values above NSTAGES are never driven.
- Match rule for a source rn against stage k: st_we[k] && st_rn[k]==rn && !(ZERO_HARD && rn==0).
- Select value: the lowest-numbered matching stage wins (nearest producer); no match gives 0.
- id_fw_sel[i]:
  - Combinational from id_rn[i].
  - Forced to 0 when id_use[i]==0 or id_valid==0.
- ex_fw_sel[i]:
  - Combinational, from registered ex_rn[i] and ex_use[i], using the same match rule.
  - Forced to 0 when ex_use[i]==0 or ex_valid==0.
- stall = id_valid && !flush && (for some i with id_use[i], the nearest matching stage for id_rn[i] has st_rdy==0).
  - Further stages are never considered once the nearest match is found, even if they are ready.
- EX register update, every posedge clk:
  - rst: ex_rn=0, ex_use=0, ex_valid=0.
  - else if flush or stall or !id_valid: bubble; ex_rn=0, ex_use=0, ex_valid=0.
  - else: ex_rn<=id_rn, ex_use<=id_use, ex_valid<=1.
- Latency: an ID source appears on ex_fw_sel exactly 1 cycle after it is accepted (no stall, no flush).
- flush has priority over stall: stall is 0 during flush and the bubble is inserted.
- stall_cnt:
  - 0 on rst.
  - Increments on each cycle with stall==1.
  - Holds at 2^CNT_W-1 (no wrap).
- Reset values: ex_valid=0, stall_cnt=0, ex_fw_sel=0. id_fw_sel and stall are combinational and are 0 whenever id_valid==0.
- Reset asserted mid-stall: the next cycle gives ex_valid=0 and stall_cnt=0. stall still follows the current inputs.
- Stall-free invariant: ex_fw_sel never points at a stage with st_rdy==0. The bench asserts this.

Test Plan:
- Defaults used throughout. ALU forward: st_we=01, st_rn[0]=5, id_rn={rt=7, rs=5}, id_use=11 -> id_fw_sel rs=1, rt=0. Next cycle, with stage 0 still writing 5, ex_fw_sel rs=1.
- Priority and zero register:
  - Both stages write r9 -> select=1.
  - Both stages write r0 with id_rn rs=0 -> select=0 and no stall.
- Load-use: st_we=01, st_rn[0]=4, st_rdy=00, rs=4 used -> stall=1, next-cycle ex_valid=0, stall_cnt=1. With st_rdy=01 the following cycle -> stall=0, and the cycle after that ex_valid=1.
- Unused source: the same load hazard with id_use=10 (rt-only use) and rs=4 -> stall=0.
- Flush during hazard: the load-use condition with flush=1 -> stall=0, ex_valid=0 next cycle, stall_cnt unchanged.
- Counter saturation (CNT_W=4): hold the hazard for 20 cycles -> stall_cnt=15. Then assert rst for 1 cycle -> stall_cnt=0, ex_valid=0.
